// File: rtl/serial_adder.sv
// Serial adder/subtractor: WIDTH-bit a +/- b, CHUNK bits per cycle, carry rippled through a register.
// Latency WIDTH/CHUNK cycles accept->out_valid; result held while out_ready=0, no new accept until consumed.
// Optional signed overflow output enabled by macro SERIAL_ADDER_OVF_EN (ovf tied 0 otherwise).
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("serial_adder: illegal WIDTH/CHUNK combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             out_valid_q;
    logic             in_ready_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             last_chunk;

    always_comb begin
        a_chunk    = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk    = b_q[cnt_q*CHUNK +: CHUNK];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        last_chunk = (cnt_q == CW'(N - 1));
        sum_d      = sum_q;
        sum_d[cnt_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= sub ? ~b : b;
                        // subtract is a + ~b + 1, so cin is replaced by the +1
                        carry_q    <= sub | cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= chunk_sum[CHUNK];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_chunk) begin
                        cout_q      <= chunk_sum[CHUNK];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
            ovf_q   <= 1'b0;
        end else if (state_q == RUN && last_chunk) begin
            ovf_q <= (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
